fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller that sequences the instruction register of the 16-bit TSC pipeline. It owns the PC and issues word-addressed reads to instruction memory. It drives the IR's `write`/`nop` controls so the decode stage sees exactly one valid instruction, or a nop bubble, per cycle. It absorbs memory latency, decode-stage stalls and branch/jump redirects.

## Interface
- `WORD_SIZE`, 16, instruction/address width
- `RESET_PC`, 0, PC value loaded on reset

- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  decode stage cannot accept a new instruction this cycle
- `flush`  in  1  redirect request from branch/jump resolution
- `flush_target`  in  WORD_SIZE  new PC, valid when `flush`=1
- `i_readM`  out  1  instruction-memory read request
- `i_address`  out  WORD_SIZE  read address (= `pc`)
- `i_data`  in  WORD_SIZE  read data, valid when `i_ready`=1
- `i_ready`  in  1  memory completes the read this cycle
- `ir_write`  out  1  to IR `write`
- `ir_nop`  out  1  to IR `nop`
- `ir_data`  out  WORD_SIZE  to IR `write_data`
- `ir_pc`  out  WORD_SIZE  PC of instruction being written (= `pc` when `ir_write`=1)
- `num_inst`  out  WORD_SIZE  count of instructions delivered to IR

## Operation
- Registers: `pc`, `state` ∈ {FETCH, HOLD, REDIRECT}, `buf` (WORD_SIZE), `num_inst`.
- Priority: `reset` > `flush` > `stall` > normal.
- `ir_write` and `ir_nop` are never both 1. `ir_nop`=1 whenever IR is not written and `stall`=0. With `stall`=1 and no flush, both are 0 and IR holds.
- FETCH:
  - `i_readM`=1, `i_address`=`pc`.
  - `i_ready` & !`stall`: `ir_write`=1, `ir_data`=`i_data`, `pc`←`pc`+1, `num_inst`+1, stay FETCH.
  - `i_ready` & `stall`: `buf`←`i_data`, go HOLD. `pc` is not incremented.
  - !`i_ready`: keep request, `pc` unchanged, `ir_nop`=!`stall`.
- HOLD:
  - `i_readM`=0.
  - !`stall`: `ir_write`=1, `ir_data`=`buf`, `pc`←`pc`+1, `num_inst`+1, go FETCH.
  - `stall`: hold everything.
- REDIRECT:
  - One bubble cycle: `i_readM`=0, `ir_nop`=1, `ir_write`=0.
  - Next state is FETCH.
- `flush` in any state:
  - `ir_nop`=1 and `ir_write`=0, regardless of `stall`.
  - Any same-cycle `i_data` or `buf` content is discarded.
  - `pc`←`flush_target`, go REDIRECT. `num_inst` unchanged.
  - `flush` during REDIRECT reloads the target and stays in REDIRECT.
- Arithmetic: `pc`+1 and `num_inst`+1 are modulo 2^WORD_SIZE; 0xFFFF wraps to 0x0000.
- `ir_data` equals `i_data` in FETCH and `buf` in HOLD; don't-care when `ir_write`=0.
- Reset:
  - Next state: `state`=FETCH, `pc`=`RESET_PC`, `num_inst`=0, `buf`=0.
  - While `reset`=1, outputs are forced: `i_readM`=0, `ir_write`=0, `ir_nop`=1, `i_address`=`pc`.
  - Reset mid-access abandons the outstanding read. Memory treats a deasserted `i_readM` as abort.

## Timing
- Outputs are combinational from state and inputs; all registers update on posedge `clk`.
- Memory handshake:
  - `i_readM` stays high with a stable `i_address` until the cycle `i_ready`=1.
  - A new request may begin the very next cycle.
- Fetch latency: `i_ready` in cycle N with no stall → `ir_write`=1 in N. IR holds the instruction from N+1, and `i_address`=`pc`+1 in N+1.
- Throughput: 1 instruction/cycle when `i_ready` is held high.
- Stall at fetch completion: data delivered in the first cycle with `stall`=0, from `buf`. Next request begins the cycle after delivery.
- Flush in cycle N:
  - N: nop.
  - N+1: REDIRECT, nop, no request.
  - N+2: request to `flush_target`.
- `stall` with `flush` in the same cycle: flush wins.

## Test plan
- Reset with `RESET_PC`=0x0010, then `i_ready`=1 every cycle, `i_data`=0x1000+addr → `i_address` 0x0010, 0x0011, 0x0012 on consecutive cycles; IR receives 0x1010, 0x1011, 0x1012; `num_inst`=3.
- Memory latency 3 cycles per read, no stall → `i_readM` high with constant address for 3 cycles; `ir_nop`=1 on the two wait cycles; `ir_write` on the third.
- `stall`=1 for 2 cycles coinciding with `i_ready` (data 0xABCD) → HOLD entered; `ir_write`=`ir_nop`=0 while stalled; 0xABCD written the first unstalled cycle; `pc` advances by exactly 1.
- `flush`=1 with `flush_target`=0x0040 in the same cycle as `i_ready` and `stall` → `ir_nop`=1, data dropped; one REDIRECT cycle with `i_readM`=0; next request at 0x0040; `num_inst` unchanged.
- PC wrap: start at 0xFFFE, with `i_ready` each cycle → addresses 0xFFFE, 0xFFFF, 0x0000.
- `reset` asserted while a read is waiting (`i_ready`=0) → next cycle `i_readM`=0, `ir_nop`=1, `pc`=`RESET_PC`, `num_inst`=0; fetch resumes from `RESET_PC` after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 16-bit TSC pipeline.
// Owns the PC, issues word-addressed reads to instruction memory and
// feeds the IR with exactly one instruction or one nop bubble per cycle.
// It absorbs memory wait states, decode stalls and branch/jump redirects.
module fetch_ctrl #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] flush_target,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic                 ir_write,
  output logic                 ir_nop,
  output logic [WORD_SIZE-1:0] ir_data,
  output logic [WORD_SIZE-1:0] ir_pc,
  output logic [WORD_SIZE-1:0] num_inst
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    REDIRECT
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] hold_buf;

  assign i_address = pc;
  assign ir_pc     = pc;

  // Decode the memory request and IR controls from the current state and inputs;
  // reset and flush both force a bubble and drop whatever the memory returns.
  always_comb begin
    i_readM  = 1'b0;
    ir_write = 1'b0;
    ir_nop   = 1'b0;
    ir_data  = i_data;
    if (reset) begin
      ir_nop = 1'b1;
    end else if (flush) begin
      ir_nop = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          i_readM = 1'b1;
          if (i_ready && !stall) begin
            ir_write = 1'b1;
          end else begin
            ir_nop = !stall;
          end
        end
        HOLD: begin
          ir_data = hold_buf;
          if (!stall) begin
            ir_write = 1'b1;
          end
        end
        REDIRECT: begin
          ir_nop = 1'b1;
        end
        default: begin
          ir_nop = 1'b1;
        end
      endcase
    end
  end

  // Advance PC, state, the parked word and the delivered-instruction count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      num_inst <= '0;
      hold_buf <= '0;
    end else if (flush) begin
      pc    <= flush_target;
      state <= REDIRECT;
    end else begin
      unique case (state)
        FETCH: begin
          if (i_ready) begin
            if (!stall) begin
              pc       <= pc + ONE;
              num_inst <= num_inst + ONE;
            end else begin
              hold_buf <= i_data;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc       <= pc + ONE;
            num_inst <= num_inst + ONE;
            state    <= FETCH;
          end
        end
        REDIRECT: begin
          state <= FETCH;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a
// behavioural model of the fetch rules (PC, delivered count, words waiting
// for the decoder, pending redirect bubble).
module tb_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [15:0] flush_target;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        ir_write;
  logic        ir_nop;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic [15:0] num_inst;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_num;
  logic [15:0] m_waiting[$];
  int          m_bubble;

  fetch_ctrl #(
    .WORD_SIZE(16),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .flush_target(flush_target),
    .i_readM     (i_readM),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .ir_write    (ir_write),
    .ir_nop      (ir_nop),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .num_inst    (num_inst)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl, input logic [15:0] tgt,
                               input logic st, input logic rdy, input logic [15:0] dat);
    reset        = rst;
    flush        = fl;
    flush_target = tgt;
    stall        = st;
    i_ready      = rdy;
    i_data       = dat;
  endtask

  task automatic checkOutput();
    logic        e_read;
    logic        e_write;
    logic        e_nop;
    logic        do_read;
    logic        do_nop;
    logic [15:0] e_data;
    do_read = 1'b1;
    do_nop  = 1'b1;
    e_read  = 1'b0;
    e_write = 1'b0;
    e_nop   = 1'b0;
    e_data  = 16'h0000;
    if (reset) begin
      e_nop = 1'b1;
    end else if (flush) begin
      e_nop   = 1'b1;
      do_read = 1'b0;
    end else if (m_bubble != 0) begin
      e_nop  = 1'b1;
      do_nop = !stall;
    end else if (m_waiting.size() != 0) begin
      e_write = !stall;
      e_data  = m_waiting[0];
    end else begin
      e_read  = 1'b1;
      e_write = i_ready && !stall;
      e_nop   = !i_ready && !stall;
      e_data  = i_data;
    end
    chk("i_address", i_address, m_pc);
    chk("num_inst", num_inst, m_num);
    chk("ir_write", 16'(ir_write), 16'(e_write));
    if (do_read) chk("i_readM", 16'(i_readM), 16'(e_read));
    if (do_nop) chk("ir_nop", 16'(ir_nop), 16'(e_nop));
    if (e_write) begin
      chk("ir_data", ir_data, e_data);
      chk("ir_pc", ir_pc, m_pc);
    end
  endtask

  task automatic updateModel();
    if (reset) begin
      m_pc     = RST_PC;
      m_num    = 16'h0000;
      m_bubble = 0;
      m_waiting.delete();
    end else if (flush) begin
      m_pc     = flush_target;
      m_bubble = 1;
      m_waiting.delete();
    end else if (m_bubble != 0) begin
      m_bubble = 0;
    end else if (m_waiting.size() != 0) begin
      if (!stall) begin
        void'(m_waiting.pop_front());
        m_pc  = m_pc + 16'd1;
        m_num = m_num + 16'd1;
      end
    end else if (i_ready) begin
      if (!stall) begin
        m_pc  = m_pc + 16'd1;
        m_num = m_num + 16'd1;
      end else begin
        m_waiting.push_back(i_data);
      end
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic [15:0] tgt,
                      input logic st, input logic rdy, input logic [15:0] dat);
    applyStimulus(rst, fl, tgt, st, rdy, dat);
    #3;
    checkOutput();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    m_pc     = RST_PC;
    m_num    = 16'h0000;
    m_bubble = 0;
    m_waiting.delete();

    $display("[TB] back-to-back fetch from reset PC");
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000 + m_pc);
    chk("t1_num_inst", num_inst, 16'd3);
    chk("t1_address", i_address, 16'h0013);

    $display("[TB] three-cycle memory latency");
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000 + m_pc);
    chk("t2_num_inst", num_inst, 16'd4);

    $display("[TB] stall at fetch completion");
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("t3_address", i_address, 16'h0015);
    chk("t3_num_inst", num_inst, 16'd5);

    $display("[TB] flush with ready and stall");
    step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h5555);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("t4_address", i_address, 16'h0040);
    chk("t4_num_inst", num_inst, 16'd5);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000 + m_pc);

    $display("[TB] PC wrap");
    step(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000 + m_pc);
    chk("t5_address", i_address, 16'h0001);

    $display("[TB] reset during outstanding read");
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("t6_address", i_address, RST_PC);
    chk("t6_num_inst", num_inst, 16'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000 + m_pc);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), 16'($urandom),
           ($urandom_range(2) == 0), ($urandom_range(1) == 0), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
